// File: rtl/palette_mapper.sv
// Layered indexed-colour to RGB mapper: 2-cycle pipeline (layer select, palette lookup), no stalls.
// Optional per-frame fade-to-dark when PALETTE_MAPPER_FADE_EN is defined.
module palette_mapper #(
  parameter int INDEX_W = 3,
  parameter int LAYERS  = 2,
  parameter int COLOR_W = 8
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        pix_valid,
  input  logic                        blank_n,
  input  logic [LAYERS*INDEX_W-1:0]   layer_idx,
  input  logic [LAYERS-1:0]           layer_en,
  input  logic                        pal_we,
  input  logic [INDEX_W-1:0]          pal_addr,
  input  logic [3*COLOR_W-1:0]        pal_wdata,
  input  logic                        frame_tick,
`ifdef PALETTE_MAPPER_FADE_EN
  input  logic                        fade_start,
`endif
  output logic [COLOR_W-1:0]          Red,
  output logic [COLOR_W-1:0]          Green,
  output logic [COLOR_W-1:0]          Blue,
  output logic                        out_valid,
  output logic                        fade_busy
);

  localparam int DEPTH = 1 << INDEX_W;
  localparam int PIX_W = 3 * COLOR_W;
  localparam int NARROW_SHIFT = (COLOR_W < 8) ? (8 - COLOR_W) : 0;

  // 8-bit reference channel to COLOR_W: keep the top bits when narrower, zero-extend when wider.
  function automatic logic [COLOR_W-1:0] scale_chan(input logic [7:0] c);
    logic [COLOR_W+7:0] wide;
    wide = {{COLOR_W{1'b0}}, c};
    wide = wide >> NARROW_SHIFT;
    return wide[COLOR_W-1:0];
  endfunction

  function automatic logic [PIX_W-1:0] reset_entry(input int i);
    logic [23:0] rgb;
    case (i)
      0:       rgb = 24'hFFFFFF;
      1:       rgb = 24'hFF0000;
      2:       rgb = 24'hFF8000;
      3:       rgb = 24'hFFFF00;
      4:       rgb = 24'h00FF00;
      5:       rgb = 24'h0000FF;
      6:       rgb = 24'h00FFFF;
      7:       rgb = 24'hFFFFFF;
      default: rgb = 24'h000000;
    endcase
    return {scale_chan(rgb[23:16]), scale_chan(rgb[15:8]), scale_chan(rgb[7:0])};
  endfunction

  logic [PIX_W-1:0]   pal [DEPTH];
  logic [INDEX_W-1:0] sel_idx;
  logic [INDEX_W-1:0] s1_idx;
  logic               s1_vld;
  logic               s1_blank_n;
  logic [PIX_W-1:0]   rd_rgb;
  logic [PIX_W-1:0]   shaded_rgb;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) pal[i] <= reset_entry(i);
    end else if (pal_we) begin
      pal[pal_addr] <= pal_wdata;
    end
  end

  // Later layers overwrite earlier ones, so the highest qualifying layer wins.
  always_comb begin
    sel_idx = layer_en[0] ? layer_idx[INDEX_W-1:0] : '0;
    for (int k = 1; k < LAYERS; k++) begin
      if (layer_en[k] && (layer_idx[k*INDEX_W +: INDEX_W] != '0))
        sel_idx = layer_idx[k*INDEX_W +: INDEX_W];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_idx     <= '0;
      s1_vld     <= 1'b0;
      s1_blank_n <= 1'b0;
    end else begin
      s1_idx     <= sel_idx;
      s1_vld     <= pix_valid;
      s1_blank_n <= blank_n;
    end
  end

  // Write-first: a write landing on the index being read this cycle is seen immediately.
  assign rd_rgb = (pal_we && (pal_addr == s1_idx)) ? pal_wdata : pal[s1_idx];

`ifdef PALETTE_MAPPER_FADE_EN
  logic [2:0] fade_level;
  logic       fade_active;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fade_level  <= 3'd0;
      fade_active <= 1'b0;
    end else if (fade_start) begin
      fade_level  <= 3'd0;
      fade_active <= 1'b1;
    end else if (frame_tick && fade_active) begin
      if (fade_level == 3'd7) fade_active <= 1'b0;
      else                    fade_level  <= fade_level + 3'd1;
    end
  end

  assign fade_busy  = fade_active;
  assign shaded_rgb = {rd_rgb[2*COLOR_W +: COLOR_W] >> fade_level,
                       rd_rgb[COLOR_W   +: COLOR_W] >> fade_level,
                       rd_rgb[0         +: COLOR_W] >> fade_level};
`else
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
  assign fade_busy  = 1'b0;
  assign shaded_rgb = rd_rgb;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Red       <= '0;
      Green     <= '0;
      Blue      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        if (!s1_blank_n) begin
          Red   <= '0;
          Green <= '0;
          Blue  <= '0;
        end else begin
          Red   <= shaded_rgb[2*COLOR_W +: COLOR_W];
          Green <= shaded_rgb[COLOR_W   +: COLOR_W];
          Blue  <= shaded_rgb[0         +: COLOR_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_palette_mapper.sv
// Bench for palette_mapper at default parameters; fade checks compiled in with PALETTE_MAPPER_FADE_EN.
module tb_palette_mapper;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pix_valid, blank_n, pal_we, frame_tick, fade_start;
  logic [1:0]  layer_en;
  logic [5:0]  layer_idx;
  logic [2:0]  pal_addr;
  logic [23:0] pal_wdata;
  logic [7:0]  Red, Green, Blue;
  logic        out_valid, fade_busy;

  palette_mapper dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .blank_n(blank_n),
    .layer_idx(layer_idx), .layer_en(layer_en), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_wdata(pal_wdata), .frame_tick(frame_tick),
`ifdef PALETTE_MAPPER_FADE_EN
    .fade_start(fade_start),
`endif
    .Red(Red), .Green(Green), .Blue(Blue), .out_valid(out_valid), .fade_busy(fade_busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [1:0]  en;
    logic [2:0]  i0, i1;
    logic        pv, bn, we;
    logic [2:0]  addr;
    logic [23:0] wdata;
    logic [23:0] exp_rgb;
    logic        exp_vld;
  } vec_t;

  typedef struct {
    string       name;
    logic [23:0] rgb;
    logic        vld;
    int          due;
  } exp_t;

  exp_t sb[$];
  vec_t vt[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   sb_en = 1'b1;
  exp_t mon_e;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (sb_en && sb.size() > 0) begin
      if (sb[0].due < cyc) begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_missed"}, 32'(mon_e.due), 32'(cyc));
      end else if (sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_rgb"}, {8'h0, Red, Green, Blue}, {8'h0, mon_e.rgb});
        chk({mon_e.name, "_vld"}, {31'h0, out_valid}, {31'h0, mon_e.vld});
      end
    end
  end

  function automatic vec_t mk(input string nm, input logic [1:0] en, input logic [2:0] i0, i1,
                              input logic pv, bn, we, input logic [2:0] addr,
                              input logic [23:0] wdata, exp_rgb, input logic exp_vld);
    vec_t v;
    v.name = nm; v.en = en; v.i0 = i0; v.i1 = i1; v.pv = pv; v.bn = bn; v.we = we;
    v.addr = addr; v.wdata = wdata; v.exp_rgb = exp_rgb; v.exp_vld = exp_vld;
    return v;
  endfunction

  task automatic idle();
    pix_valid = 1'b0; pal_we = 1'b0; frame_tick = 1'b0; fade_start = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    layer_en = v.en; layer_idx = {v.i1, v.i0}; pix_valid = v.pv; blank_n = v.bn;
    pal_we = v.we; pal_addr = v.addr; pal_wdata = v.wdata;
    sb.push_back('{name: v.name, rgb: v.exp_rgb, vld: v.exp_vld, due: cyc + 2});
    @(posedge Clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge Clk);
    if (sb.size() > 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    #1;
  endtask

  task automatic drive1(input vec_t v);
    drive(v); idle(); drain();
    @(posedge Clk); #1;
  endtask

  task automatic ctl(input logic fs, input logic ft);
    pix_valid = 1'b0; fade_start = fs; frame_tick = ft;
    @(posedge Clk); #1;
    fade_start = 1'b0; frame_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; idle(); blank_n = 1'b1; layer_en = '0; layer_idx = '0;
    pal_addr = '0; pal_wdata = '0;

    vt.push_back(mk("l0_idx1",    2'b01, 3'd1, 3'd0, 1, 1, 0, 3'd0, 24'h0, 24'hFF0000, 1));
    vt.push_back(mk("l1_over",    2'b11, 3'd3, 3'd5, 1, 1, 0, 3'd0, 24'h0, 24'h0000FF, 1));
    vt.push_back(mk("l1_transp",  2'b11, 3'd3, 3'd0, 1, 1, 0, 3'd0, 24'h0, 24'hFFFF00, 1));
    vt.push_back(mk("l0_dis",     2'b10, 3'd3, 3'd0, 1, 1, 0, 3'd0, 24'h0, 24'hFFFFFF, 1));
    vt.push_back(mk("none_en",    2'b00, 3'd2, 3'd6, 1, 1, 0, 3'd0, 24'h0, 24'hFFFFFF, 1));
    vt.push_back(mk("l1_only",    2'b10, 3'd2, 3'd6, 1, 1, 0, 3'd0, 24'h0, 24'h00FFFF, 1));
    vt.push_back(mk("l1_dis",     2'b01, 3'd3, 3'd5, 1, 1, 0, 3'd0, 24'h0, 24'hFFFF00, 1));
    vt.push_back(mk("hold",       2'b01, 3'd5, 3'd0, 0, 1, 0, 3'd0, 24'h0, 24'hFFFF00, 0));
    vt.push_back(mk("blank",      2'b01, 3'd1, 3'd0, 1, 0, 0, 3'd0, 24'h0, 24'h000000, 1));
    vt.push_back(mk("blank_hold", 2'b01, 3'd1, 3'd0, 0, 0, 0, 3'd0, 24'h0, 24'h000000, 0));
    vt.push_back(mk("pre_wr",     2'b01, 3'd4, 3'd0, 1, 1, 0, 3'd0, 24'h0, 24'h00FF00, 1));
    vt.push_back(mk("bypass",     2'b01, 3'd4, 3'd0, 1, 1, 0, 3'd0, 24'h0, 24'h123456, 1));
    vt.push_back(mk("wr4",        2'b01, 3'd4, 3'd0, 1, 1, 1, 3'd4, 24'h123456, 24'h123456, 1));
    vt.push_back(mk("wr_blank",   2'b01, 3'd1, 3'd0, 1, 0, 1, 3'd7, 24'hAAAAAA, 24'h000000, 1));
    vt.push_back(mk("wr_b2b",     2'b01, 3'd1, 3'd0, 1, 1, 1, 3'd7, 24'hBBBBBB, 24'hFF0000, 1));
    vt.push_back(mk("rd7_a",      2'b01, 3'd7, 3'd0, 1, 1, 0, 3'd0, 24'h0, 24'hBBBBBB, 1));
    vt.push_back(mk("rd7_b",      2'b01, 3'd7, 3'd0, 1, 1, 0, 3'd0, 24'h0, 24'hBBBBBB, 1));

    #3;
    chk("rst_rgb", {8'h0, Red, Green, Blue}, 32'h0);
    chk("rst_vld", {31'h0, out_valid}, 32'h0);
    chk("rst_busy", {31'h0, fade_busy}, 32'h0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) drive(vt[i]);
    idle();
    drain();

    // Mid-stream reset: in-flight pixels must vanish and the palette must return to defaults.
    layer_en = 2'b01; layer_idx = {3'd0, 3'd4}; pix_valid = 1'b1; blank_n = 1'b1;
    repeat (2) @(posedge Clk);
    #2;
    chk("pre_rst_rgb", {8'h0, Red, Green, Blue}, 32'h00123456);
    chk("pre_rst_vld", {31'h0, out_valid}, 32'h1);
    sb_en = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_rgb", {8'h0, Red, Green, Blue}, 32'h0);
    chk("mid_rst_vld", {31'h0, out_valid}, 32'h0);
    repeat (2) @(posedge Clk);
    #1 idle();
    Reset_n = 1'b1;
    sb.delete();
    sb_en = 1'b1;
    drive(mk("post_idle",   2'b01, 3'd4, 3'd0, 0, 1, 0, 3'd0, 24'h0, 24'h000000, 0));
    drive(mk("post_idle2",  2'b01, 3'd4, 3'd0, 0, 1, 0, 3'd0, 24'h0, 24'h000000, 0));
    drive(mk("post_rst_e4", 2'b01, 3'd4, 3'd0, 1, 1, 0, 3'd0, 24'h0, 24'h00FF00, 1));
    drive(mk("post_rst_e7", 2'b01, 3'd7, 3'd0, 1, 1, 0, 3'd0, 24'h0, 24'hFFFFFF, 1));
    idle();
    drain();

`ifdef PALETTE_MAPPER_FADE_EN
    ctl(1'b1, 1'b0);
    chk("fade_busy_start", {31'h0, fade_busy}, 32'h1);
    ctl(1'b0, 1'b1);
    ctl(1'b0, 1'b1);
    drive1(mk("fade_l2", 2'b01, 3'd0, 3'd0, 1, 1, 0, 3'd0, 24'h0, 24'h3F3F3F, 1));
    for (int i = 0; i < 5; i++) ctl(1'b0, 1'b1);
    chk("fade_busy_l7", {31'h0, fade_busy}, 32'h1);
    drive1(mk("fade_l7", 2'b01, 3'd0, 3'd0, 1, 1, 0, 3'd0, 24'h0, 24'h010101, 1));
    ctl(1'b0, 1'b1);
    chk("fade_busy_end", {31'h0, fade_busy}, 32'h0);
    drive1(mk("fade_persist", 2'b01, 3'd0, 3'd0, 1, 1, 0, 3'd0, 24'h0, 24'h010101, 1));
    ctl(1'b1, 1'b1);
    chk("fade_restart_busy", {31'h0, fade_busy}, 32'h1);
    drive1(mk("fade_restart", 2'b01, 3'd0, 3'd0, 1, 1, 0, 3'd0, 24'h0, 24'hFFFFFF, 1));
`else
    chk("nofade_busy", {31'h0, fade_busy}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
